// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int WORD_W = 10;
    localparam int RD_W   = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_CMD   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RECV  = 3'd5,
        ST_HOLD  = 3'd6,
        ST_END   = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_master_shreg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_master_shreg
// Description : Loadable 10-bit transmit shifter (serial out, MSB first) and
//               8-bit receive shifter (serial in, MSB first).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shreg
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift_out_en,
    output logic              sout,
    input  logic              shift_in_en,
    input  logic              sin,
    output logic [RD_W-1:0]   rx_word
);

    logic [WORD_W-1:0] tx_reg;

    // Transmit word: load on frame acceptance, shift left while serialising
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg <= '0;
        end else if (load) begin
            tx_reg <= load_data;
        end else if (shift_out_en) begin
            tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
        end
    end

    assign sout = tx_reg[WORD_W-1];

    // Receive byte: first sampled bit ends up in the MSB after RD_W shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_word <= '0;
        end else if (shift_in_en) begin
            rx_word <= {rx_word[RD_W-2:0], sin};
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-clock SPI master sending a 10-bit command/address/data
//               word, with an optional 8-bit read-back after RD_LATENCY idle
//               cycles. All outputs are registered from the next state so
//               they line up with the state they belong to.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [RD_W-1:0]   rd_data,
    output logic              rd_valid,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [1:0] cmd;
    logic       accept;
    logic       sout;
    logic       shift_out_en;
    logic       shift_in_en;

    assign accept       = (state == ST_IDLE) && start;
    // Shifting starts in CMD so that SHIFT's first bit repeats the command bit
    assign shift_out_en = (state == ST_CMD) || (state == ST_SHIFT);
    assign shift_in_en  = (state == ST_RECV);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_SEL;
            ST_SEL:   next_state = ST_CMD;
            ST_CMD:   next_state = ST_SHIFT;
            ST_SHIFT: if (cnt == 4'd0) next_state = (cmd == CMD_RD_DATA) ? ST_WAIT : ST_HOLD;
            ST_WAIT:  if (cnt == 4'd0) next_state = ST_RECV;
            ST_RECV:  if (cnt == 4'd0) next_state = ST_END;
            ST_HOLD:  next_state = ST_END;
            ST_END:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Phase counter: 9..0 for SHIFT, RD_LATENCY-1..0 for WAIT, 7..0 for RECV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else begin
            case (state)
                ST_CMD:   cnt <= 4'(WORD_W - 1);
                ST_SHIFT: cnt <= (cnt == 4'd0) ? 4'(RD_LATENCY - 1) : cnt - 4'd1;
                ST_WAIT:  cnt <= (cnt == 4'd0) ? 4'(RD_W - 1) : cnt - 4'd1;
                ST_RECV:  cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                default:  cnt <= 4'd0;
            endcase
        end
    end

    // Command latch; din is only looked at on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd <= 2'b00;
        end else if (accept) begin
            cmd <= din[WORD_W-1:WORD_W-2];
        end
    end

    // Registered outputs derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            SS_n     <= (next_state == ST_IDLE) || (next_state == ST_END);
            MOSI     <= ((next_state == ST_CMD) || (next_state == ST_SHIFT)) ? sout : 1'b0;
            busy     <= (next_state != ST_IDLE);
            done     <= (next_state == ST_END);
            rd_valid <= (next_state == ST_END) && (cmd == CMD_RD_DATA);
        end
    end

    spi_master_shreg u_shreg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (accept),
        .load_data    (din),
        .shift_out_en (shift_out_en),
        .sout         (sout),
        .shift_in_en  (shift_in_en),
        .sin          (MISO),
        .rx_word      (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master with a cycle-offset
//               reference model of the SPI frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] din = '0;
    logic       MISO = 1'b0;
    logic       busy, done, rd_valid, SS_n, MOSI;
    logic [7:0] rd_data;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model_rd = 8'h00;

    spi_master #(.RD_LATENCY(RD_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (SS_n !== 1'b1)   begin n_err++; $display("FAIL reset_ss_n got=%b exp=1", SS_n); end
        n_cmp++; if (MOSI !== 1'b0)   begin n_err++; $display("FAIL reset_mosi got=%b exp=0", MOSI); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        rst_n = 1'b1;
        model_rd = 8'h00;
        repeat (2) @(negedge clk);
    endtask

    // One frame launched at offset 0 (cycle T); outputs checked for every
    // cycle T+1 .. END+1. A second start with d_alt is pulsed at pulse_k
    // (0 disables). din is scrambled after acceptance.
    task automatic run_frame(input logic [9:0] d, input logic [7:0] rx,
                             input int pulse_k, input logic [9:0] d_alt,
                             input string tag);
        bit   rd;
        int   endk;
        int   recv0;
        logic e_ss, e_mo, e_dn, e_rv, e_bz;
        rd    = (d[9:8] == 2'b11);
        endk  = rd ? (12 + RD_LAT + 8 + 1) : 14;
        recv0 = 12 + RD_LAT + 1;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        MISO  = 1'($urandom);
        for (int k = 1; k <= endk + 1; k++) begin
            @(negedge clk);
            start = (k == pulse_k);
            din   = (k == pulse_k) ? d_alt : 10'($urandom);
            if (rd && k >= recv0 && k < recv0 + 8) MISO = rx[7 - (k - recv0)];
            else                                   MISO = 1'($urandom);
            e_ss = !(k >= 1 && k < endk);
            e_mo = (k == 2) ? d[9] : ((k >= 3 && k <= 12) ? d[12 - k] : 1'b0);
            e_dn = (k == endk);
            e_rv = (k == endk) && rd;
            e_bz = (k >= 1 && k <= endk);
            n_cmp++; if (SS_n !== e_ss) begin n_err++; $display("FAIL %s ss_n k=%0d got=%b exp=%b", tag, k, SS_n, e_ss); end
            n_cmp++; if (MOSI !== e_mo) begin n_err++; $display("FAIL %s mosi k=%0d got=%b exp=%b", tag, k, MOSI, e_mo); end
            n_cmp++; if (done !== e_dn) begin n_err++; $display("FAIL %s done k=%0d got=%b exp=%b", tag, k, done, e_dn); end
            n_cmp++; if (rd_valid !== e_rv) begin n_err++; $display("FAIL %s rd_valid k=%0d got=%b exp=%b", tag, k, rd_valid, e_rv); end
            n_cmp++; if (busy !== e_bz) begin n_err++; $display("FAIL %s busy k=%0d got=%b exp=%b", tag, k, busy, e_bz); end
            if (k == endk) begin
                if (rd) model_rd = rx;
                n_cmp++;
                if (rd_data !== model_rd) begin
                    n_err++; $display("FAIL %s rd_data got=%h exp=%h", tag, rd_data, model_rd);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_write_addr_vector();
        run_frame(10'h0A5, 8'h00, 0, 10'h000, "wr_addr_0a5");
    endtask

    task automatic test_read_vector();
        run_frame({2'b11, 8'h5A}, 8'hC3, 0, 10'h000, "rd_data_c3");
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 8; i++) begin
            logic [9:0] d;
            logic [7:0] b;
            d = 10'($urandom);
            b = 8'($urandom);
            run_frame(d, b, 0, 10'h000, "random");
        end
    endtask

    task automatic test_ignore_start();
        logic [9:0] d;
        d = {2'b01, 8'($urandom)};
        run_frame(d, 8'h00, 5, ~d, "ignore_start");
        // the extra start pulse must not have spawned a second frame
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if (SS_n !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL ignore_start_extra ss_n=%b done=%b exp ss_n=1 done=0", SS_n, done); end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        start = 1'b1;
        din   = {2'b11, 8'($urandom)};
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (SS_n !== 1'b1) begin n_err++; $display("FAIL midrst_ss_n got=%b exp=1", SS_n); end
        n_cmp++; if (MOSI !== 1'b0) begin n_err++; $display("FAIL midrst_mosi got=%b exp=0", MOSI); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b/%b exp=0/0", done, rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL midrst_rd_data got=%h exp=00", rd_data); end
        model_rd = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_cmp++; if (done !== 1'b0 || SS_n !== 1'b1) begin n_err++; $display("FAIL midrst_after done=%b ss_n=%b exp done=0 ss_n=1", done, SS_n); end
        end
        run_frame({2'b01, 8'($urandom)}, 8'h00, 0, 10'h000, "after_reset");
    endtask

    // start held high: decode each SS_n-low window like a slave would
    task automatic test_back_to_back();
        logic       ss_rec [0:60];
        logic       mo_rec [0:60];
        int         n_done;
        int         n_frames;
        int         last_rise;
        logic [9:0] d;
        d = {1'b0, 9'($urandom)};
        n_done = 0;
        n_frames = 0;
        last_rise = -1;
        ss_rec[0] = 1'b1;
        mo_rec[0] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        din   = d;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 60) start = 1'b0;
            ss_rec[k] = SS_n;
            mo_rec[k] = MOSI;
            if (done === 1'b1) n_done++;
        end
        for (int k = 1; k <= 47; k++) begin
            if (ss_rec[k-1] === 1'b1 && ss_rec[k] === 1'b0) begin
                logic [9:0] w;
                int         low;
                n_frames++;
                if (last_rise >= 0) begin
                    n_cmp++;
                    if (k - last_rise !== 2) begin n_err++; $display("FAIL b2b_gap got=%0d exp=2", k - last_rise); end
                end
                low = 0;
                while (k + low <= 60 && ss_rec[k + low] === 1'b0) low++;
                last_rise = k + low;
                n_cmp++;
                if (low !== 13) begin n_err++; $display("FAIL b2b_low_len got=%0d exp=13", low); end
                for (int j = 0; j < 10; j++) w[9 - j] = mo_rec[k + 2 + j];
                n_cmp++;
                if (w !== d) begin n_err++; $display("FAIL b2b_rx_data got=%h exp=%h", w, d); end
            end
        end
        n_cmp++; if (n_frames !== 4) begin n_err++; $display("FAIL b2b_frames got=%0d exp=4", n_frames); end
        n_cmp++; if (n_done !== 4)   begin n_err++; $display("FAIL b2b_done got=%0d exp=4", n_done); end
        repeat (16) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_addr_vector();
        test_read_vector();
        test_random_frames();
        test_ignore_start();
        test_reset_mid_frame();
        test_back_to_back();
        test_read_vector();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: RD_LATENCY, 2, idle cycles between the last MOSI bit of a read-data frame and the first MISO sample (range 1..15).
REQ-002 clk  input  1  single clock; all registers update on rising edge; also serves as SPI bit clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to launch a frame; honoured only when busy=0.
REQ-005 din  input  10  frame word: din[9:8]=command, din[7:0]=address/data.
REQ-006 busy  output  1  high from the cycle after an accepted start until the end of the frame's END cycle.
REQ-007 done  output  1  one-cycle pulse at frame completion.
REQ-008 rd_data  output  8  byte captured from MISO in a read-data frame.
REQ-009 rd_valid  output  1  one-cycle pulse, concurrent with done, only for read-data frames.
REQ-010 SS_n  output  1  slave select, active-low, registered.
REQ-011 MOSI  output  1  serial data to slave, registered, MSB first.
REQ-012 MISO  input  1  serial data from slave, sampled on rising edge of clk.

Function
REQ-013 Commands: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-014 States: IDLE, SEL, CMD, SHIFT, WAIT, RECV, HOLD, END.
REQ-015 IDLE: SS_n=1, MOSI=0; start=1 at cycle T latches din and moves to SEL.
REQ-016 SEL (T+1): SS_n=0, MOSI=0; moves to CMD.
REQ-017 CMD (T+2): MOSI=din[9] (command-select bit); moves to SHIFT.
REQ-018 SHIFT (T+3..T+12): MOSI=din[9] down to din[0], one bit per cycle, 4-bit down-counter 9..0.
REQ-019 After SHIFT: commands 00/01/10 go to HOLD; command 11 goes to WAIT.
REQ-020 HOLD: one cycle, SS_n=0, MOSI=0, lets the slave flag rx_valid; then END.
REQ-021 WAIT: RD_LATENCY cycles, SS_n=0, MOSI=0; then RECV.
REQ-022 RECV: 8 cycles, MISO shifted into rd_data MSB first (first sample -> rd_data[7]); SS_n=0; then END.
REQ-023 END: SS_n=1, MOSI=0, done=1 (rd_valid=1 if command 11); then IDLE; guarantees SS_n high for at least one cycle between frames.
REQ-024 Frame lengths: write-type = T+1..T+13 with SS_n low (13 cycles), END at T+14; read-data SS_n low 12+RD_LATENCY+8 cycles.
REQ-025 start while busy=1 is ignored, no queueing; din changes after acceptance have no effect.
REQ-026 start in the END cycle is ignored; start in IDLE the cycle after END is accepted.
REQ-027 rd_data holds its value until the next read-data frame's RECV overwrites it; not altered by write frames.
REQ-028 MISO is ignored outside RECV.

Reset
REQ-029 rst_n low forces immediately: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, counters 0.
REQ-030 Reset asserted mid-frame aborts the frame with no done/rd_valid pulse; first start after rst_n release starts a fresh frame.

Structure
REQ-031 Package spi_pkg holds: state enum, command constants (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), frame constants (WORD_W=10, RD_W=8).
REQ-032 One sub-module spi_master_shreg: loadable 10-bit shift register with serial-out (MOSI path) and 8-bit serial-in (MISO path).

Verification
REQ-033 start with din=10'h0A5 (write-address) -> SS_n low T+1..T+13, MOSI T+2=0 then 0,0,1,0,1,0,0,1,0,1 over T+3..T+12, done at T+14, rd_valid=0.
REQ-034 din=10'h3xx (read-data, RD_LATENCY=2), MISO driven 8'hC3 MSB first from T+15 -> rd_data=8'hC3, rd_valid and done together at T+23, SS_n high at T+23.
REQ-035 start pulsed at T+5 during a frame with different din -> ignored, MOSI stream unchanged, exactly one done.
REQ-036 rst_n low at T+7 of a read-data frame -> SS_n=1, MOSI=0, busy=0 same cycle, no done; new write-data frame after release completes normally.
REQ-037 Back-to-back: start held high continuously -> frames separated by exactly one SS_n-high END cycle plus IDLE acceptance cycle; against the SPI slave each write-type frame produces rx_valid with rx_data equal to din.
